sdram_pro_fifo_ctrl: RTL and testbench
======================================

SDRAM_PRO_FIFO_CTRL -- requirements
Module: sdram_pro_fifo_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 23, meaning SDRAM linear address width (bank+row+column).
REQ-002 The block SHALL have parameter LEN_W, default 10, meaning burst-length and FIFO-level width.
REQ-003 The block SHALL have port sys_clk, input, 1, the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port sys_rst_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port init_end, input, 1, SDRAM init done; no requests while low.
REQ-006 The block SHALL have ports wr_b_addr / wr_e_addr, input, ADDR_W, write region begin / end (end exclusive).
REQ-007 The block SHALL have ports rd_b_addr / rd_e_addr, input, ADDR_W, read region begin / end (end exclusive).
REQ-008 The block SHALL have ports wr_burst_len / rd_burst_len, input, LEN_W, words per burst.
REQ-009 The block SHALL have ports wr_addr_rst / rd_addr_rst, input, 1, one-cycle pulse reloading the write / read pointer to its begin address.
REQ-010 The block SHALL have ports wr_fifo_usedw / rd_fifo_usedw, input, LEN_W, fill level of write-side / read-side FIFO.
REQ-011 The block SHALL have port read_valid, input, 1, read-back enable.
REQ-012 The block SHALL have ports sdram_wr_ack / sdram_rd_ack, input, 1, per-word acknowledge from the SDRAM controller.
REQ-013 The block SHALL have ports sdram_wr_req / sdram_rd_req, output, 1, burst request to the SDRAM controller.
REQ-014 The block SHALL have ports sdram_wr_addr / sdram_rd_addr, output, ADDR_W, burst start address.
REQ-015 The block SHALL have ports wr_fifo_rden / rd_fifo_wren, output, 1, combinational copies of sdram_wr_ack / sdram_rd_ack.

Function
REQ-016 The FSM SHALL have states IDLE, ARB, WR, RD; reset state IDLE.
REQ-017 IDLE SHALL go to ARB on the next cycle when init_end=1; otherwise it SHALL stay in IDLE.
REQ-018 ARB SHALL enter WR when wr_burst_len!=0 and wr_fifo_usedw>=wr_burst_len.
REQ-019 Otherwise ARB SHALL enter RD when read_valid=1, rd_burst_len!=0 and rd_fifo_usedw<rd_burst_len; otherwise it SHALL stay in ARB.
REQ-020 When both write and read conditions hold, write SHALL win; zero burst length SHALL never raise a request.
REQ-021 sdram_wr_req SHALL be registered, rising in the first WR cycle and falling the cycle after sdram_wr_ack is first sampled high; RD with sdram_rd_req SHALL behave identically.
REQ-022 A burst SHALL end on a registered falling edge of the matching ack; the FSM SHALL then return to ARB in the next cycle.
REQ-023 In that same end cycle, the pointer SHALL advance by burst_len; if pointer+burst_len>=e_addr, it SHALL reload b_addr (wrap), computed at ADDR_W+1 bits to avoid overflow.
REQ-024 sdram_*_addr SHALL equal the registered pointer and SHALL stay stable while the matching req or ack is high.
REQ-025 An addr_rst pulse in IDLE/ARB SHALL load b_addr next cycle; a pulse during the matching burst SHALL be latched and applied at burst end instead of the advance.
REQ-026 If init_end falls mid-burst, the burst SHALL complete normally; the FSM SHALL then go to IDLE instead of ARB.
REQ-027 The block SHALL never assert sdram_wr_req and sdram_rd_req simultaneously.

Reset
REQ-028 While sys_rst_n=0: state IDLE, both req=0, pointers = wr_b_addr / rd_b_addr sampled at reset release, pending addr_rst flags cleared.
REQ-029 Reset assertion mid-burst SHALL drop req asynchronously; no pointer advance SHALL occur.

Verification
REQ-030 init_end=1, wr_burst_len=8, wr_fifo_usedw 7->8 -> sdram_wr_req rises two cycles after usedw=8, sdram_wr_addr=wr_b_addr.
REQ-031 Eight-cycle ack burst with wr_b_addr=0, wr_e_addr=24 -> addr sequence 0, 8, 16, 0 over four bursts (wrap).
REQ-032 Write and read conditions both true in ARB -> write served first, read request follows after write ack falls.
REQ-033 rd_addr_rst pulse during read burst at addr 16 -> next sdram_rd_addr = rd_b_addr, not 24.
REQ-034 sys_rst_n low during write ack -> sdram_wr_req=0 immediately; after release first write addr = wr_b_addr.
REQ-035 wr_burst_len=0 with wr_fifo_usedw=100 -> sdram_wr_req never asserted.

Source files
------------

// File: rtl/sdram_pro_fifo_ctrl.sv
// Burst arbiter between write/read FIFOs and an SDRAM controller.
// Keeps wrapping linear address pointers for both regions.
module sdram_pro_fifo_ctrl #(
   parameter int ADDR_W = 23,
   parameter int LEN_W  = 10
) (
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   input  logic              init_end,
   input  logic [ADDR_W-1:0] wr_b_addr,
   input  logic [ADDR_W-1:0] wr_e_addr,
   input  logic [ADDR_W-1:0] rd_b_addr,
   input  logic [ADDR_W-1:0] rd_e_addr,
   input  logic [LEN_W-1:0]  wr_burst_len,
   input  logic [LEN_W-1:0]  rd_burst_len,
   input  logic              wr_addr_rst,
   input  logic              rd_addr_rst,
   input  logic [LEN_W-1:0]  wr_fifo_usedw,
   input  logic [LEN_W-1:0]  rd_fifo_usedw,
   input  logic              read_valid,
   input  logic              sdram_wr_ack,
   input  logic              sdram_rd_ack,
   output logic              sdram_wr_req,
   output logic              sdram_rd_req,
   output logic [ADDR_W-1:0] sdram_wr_addr,
   output logic [ADDR_W-1:0] sdram_rd_addr,
   output logic              wr_fifo_rden,
   output logic              rd_fifo_wren
);

   localparam int PW = ADDR_W + 1;

   typedef enum logic [1:0] {IDLE, ARB, WR, RD} state_t;

   state_t state, state_nxt;

   logic [ADDR_W-1:0] wr_ptr, rd_ptr;
   logic [ADDR_W-1:0] wr_ptr_nxt, rd_ptr_nxt;
   logic [PW-1:0]     wr_sum, rd_sum;
   logic wr_ack_d, rd_ack_d;
   logic wr_seen, rd_seen;
   logic wr_pend, rd_pend;
   logic wr_go, rd_go;
   logic wr_end, rd_end;

   assign wr_go = (wr_burst_len != '0) && (wr_fifo_usedw >= wr_burst_len);
   assign rd_go = read_valid && (rd_burst_len != '0)
                  && (rd_fifo_usedw < rd_burst_len);

   // burst finishes on the registered falling edge of the ack
   assign wr_end = (state == WR) && wr_ack_d && !sdram_wr_ack;
   assign rd_end = (state == RD) && rd_ack_d && !sdram_rd_ack;

   // extra bit keeps ptr+len from wrapping before the compare
   assign wr_sum = PW'(wr_ptr) + PW'(wr_burst_len);
   assign rd_sum = PW'(rd_ptr) + PW'(rd_burst_len);

   assign wr_ptr_nxt = (wr_pend || wr_addr_rst)    ? wr_b_addr :
                       (wr_sum >= PW'(wr_e_addr)) ? wr_b_addr :
                                                    wr_sum[ADDR_W-1:0];
   assign rd_ptr_nxt = (rd_pend || rd_addr_rst)    ? rd_b_addr :
                       (rd_sum >= PW'(rd_e_addr)) ? rd_b_addr :
                                                    rd_sum[ADDR_W-1:0];

   assign sdram_wr_addr = wr_ptr;
   assign sdram_rd_addr = rd_ptr;
   assign wr_fifo_rden  = sdram_wr_ack;
   assign rd_fifo_wren  = sdram_rd_ack;

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (init_end) state_nxt = ARB;
         ARB: begin
            if (!init_end)  state_nxt = IDLE;
            else if (wr_go) state_nxt = WR;
            else if (rd_go) state_nxt = RD;
         end
         WR: if (wr_end) state_nxt = init_end ? ARB : IDLE;
         RD: if (rd_end) state_nxt = init_end ? ARB : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state        <= IDLE;
         sdram_wr_req <= 1'b0;
         sdram_rd_req <= 1'b0;
         wr_ptr       <= wr_b_addr;
         rd_ptr       <= rd_b_addr;
         wr_ack_d     <= 1'b0;
         rd_ack_d     <= 1'b0;
         wr_seen      <= 1'b0;
         rd_seen      <= 1'b0;
         wr_pend      <= 1'b0;
         rd_pend      <= 1'b0;
      end else begin
         state    <= state_nxt;
         wr_ack_d <= sdram_wr_ack;
         rd_ack_d <= sdram_rd_ack;
         // req held until the first ack sample, never re-raised in a burst
         wr_seen      <= (state == WR) && (wr_seen || sdram_wr_ack);
         rd_seen      <= (state == RD) && (rd_seen || sdram_rd_ack);
         sdram_wr_req <= (state == WR) && !wr_seen && !sdram_wr_ack;
         sdram_rd_req <= (state == RD) && !rd_seen && !sdram_rd_ack;

         if (wr_end)
            wr_ptr <= wr_ptr_nxt;
         else if (wr_addr_rst && state != WR)
            wr_ptr <= wr_b_addr;
         if (rd_end)
            rd_ptr <= rd_ptr_nxt;
         else if (rd_addr_rst && state != RD)
            rd_ptr <= rd_b_addr;

         if (wr_end)
            wr_pend <= 1'b0;
         else if (wr_addr_rst && state == WR)
            wr_pend <= 1'b1;
         if (rd_end)
            rd_pend <= 1'b0;
         else if (rd_addr_rst && state == RD)
            rd_pend <= 1'b1;
      end
   end

endmodule

// File: tb/tb_sdram_pro_fifo_ctrl.sv
// Directed bench for sdram_pro_fifo_ctrl.
// Expected addresses and timings are hand computed.
module tb_sdram_pro_fifo_ctrl;

   logic        sys_clk;
   logic        sys_rst_n;
   logic        init_end;
   logic [22:0] wr_b_addr, wr_e_addr, rd_b_addr, rd_e_addr;
   logic [9:0]  wr_burst_len, rd_burst_len;
   logic        wr_addr_rst, rd_addr_rst;
   logic [9:0]  wr_fifo_usedw, rd_fifo_usedw;
   logic        read_valid;
   logic        sdram_wr_ack, sdram_rd_ack;
   logic        sdram_wr_req, sdram_rd_req;
   logic [22:0] sdram_wr_addr, sdram_rd_addr;
   logic        wr_fifo_rden, rd_fifo_wren;

   int errs   = 0;
   int checks = 0;

   sdram_pro_fifo_ctrl #(.ADDR_W(23), .LEN_W(10)) dut (
      .sys_clk       (sys_clk),
      .sys_rst_n     (sys_rst_n),
      .init_end      (init_end),
      .wr_b_addr     (wr_b_addr),
      .wr_e_addr     (wr_e_addr),
      .rd_b_addr     (rd_b_addr),
      .rd_e_addr     (rd_e_addr),
      .wr_burst_len  (wr_burst_len),
      .rd_burst_len  (rd_burst_len),
      .wr_addr_rst   (wr_addr_rst),
      .rd_addr_rst   (rd_addr_rst),
      .wr_fifo_usedw (wr_fifo_usedw),
      .rd_fifo_usedw (rd_fifo_usedw),
      .read_valid    (read_valid),
      .sdram_wr_ack  (sdram_wr_ack),
      .sdram_rd_ack  (sdram_rd_ack),
      .sdram_wr_req  (sdram_wr_req),
      .sdram_rd_req  (sdram_rd_req),
      .sdram_wr_addr (sdram_wr_addr),
      .sdram_rd_addr (sdram_rd_addr),
      .wr_fifo_rden  (wr_fifo_rden),
      .rd_fifo_wren  (rd_fifo_wren)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   always @(negedge sys_clk)
      chk("mutex", {31'b0, sdram_wr_req & sdram_rd_req}, 32'd0);

   always @(negedge sys_clk)
      chk("ack_copy", {30'b0, wr_fifo_rden, rd_fifo_wren},
          {30'b0, sdram_wr_ack, sdram_rd_ack});

   task automatic wr_burst(input logic [22:0] exp, input bit drop_init,
                           input bit rd_hold);
      bit seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         if (sdram_wr_req) seen = 1;
         else tick();
      end
      chk("wr_req_seen", {31'b0, seen}, 32'd1);
      chk("wr_addr", {9'b0, sdram_wr_addr}, {9'b0, exp});
      if (rd_hold) chk("rd_held", {31'b0, sdram_rd_req}, 32'd0);
      sdram_wr_ack = 1'b1;
      tick();
      chk("wr_req_fall", {31'b0, sdram_wr_req}, 32'd0);
      for (int i = 0; i < 7; i++) begin
         if (i == 3 && drop_init) init_end = 1'b0;
         tick();
      end
      chk("wr_addr_hold", {9'b0, sdram_wr_addr}, {9'b0, exp});
      sdram_wr_ack = 1'b0;
   endtask

   task automatic rd_burst(input logic [22:0] exp, input bit pulse);
      bit seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         if (sdram_rd_req) seen = 1;
         else tick();
      end
      chk("rd_req_seen", {31'b0, seen}, 32'd1);
      chk("rd_addr", {9'b0, sdram_rd_addr}, {9'b0, exp});
      sdram_rd_ack = 1'b1;
      tick();
      chk("rd_req_fall", {31'b0, sdram_rd_req}, 32'd0);
      for (int i = 0; i < 7; i++) begin
         rd_addr_rst = (i == 3) && pulse;
         tick();
      end
      rd_addr_rst = 1'b0;
      sdram_rd_ack = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: sim time exceeded");
      $fatal(1);
   end

   initial begin
      bit seen;
      sys_rst_n     = 1'b0;
      init_end      = 1'b1;
      wr_b_addr     = 23'd0;
      wr_e_addr     = 23'd24;
      rd_b_addr     = 23'd100;
      rd_e_addr     = 23'd132;
      wr_burst_len  = 10'd8;
      rd_burst_len  = 10'd8;
      wr_addr_rst   = 1'b0;
      rd_addr_rst   = 1'b0;
      wr_fifo_usedw = 10'd0;
      rd_fifo_usedw = 10'd16;
      read_valid    = 1'b0;
      sdram_wr_ack  = 1'b0;
      sdram_rd_ack  = 1'b0;
      repeat (3) tick();
      chk("rst_wr_req", {31'b0, sdram_wr_req}, 32'd0);
      chk("rst_rd_req", {31'b0, sdram_rd_req}, 32'd0);
      chk("rst_wr_addr", {9'b0, sdram_wr_addr}, 32'd0);
      chk("rst_rd_addr", {9'b0, sdram_rd_addr}, 32'd100);
      sys_rst_n = 1'b1;
      repeat (3) tick();
      chk("idle_no_req", {31'b0, sdram_wr_req}, 32'd0);

      // request latency: two edges after usedw reaches burst length
      wr_fifo_usedw = 10'd7;
      repeat (2) tick();
      chk("below_len", {31'b0, sdram_wr_req}, 32'd0);
      wr_fifo_usedw = 10'd8;
      tick();
      chk("req_lat1", {31'b0, sdram_wr_req}, 32'd0);
      tick();
      chk("req_lat2", {31'b0, sdram_wr_req}, 32'd1);

      // wrap: 0, 8, 16, 0 in region [0,24)
      wr_burst(23'd0, 0, 0);
      wr_burst(23'd8, 0, 0);
      wr_burst(23'd16, 0, 0);
      wr_burst(23'd0, 0, 0);
      wr_fifo_usedw = 10'd0;
      repeat (3) tick();
      chk("ptr_after_wrap", {9'b0, sdram_wr_addr}, 32'd8);

      // addr_rst while arbitrating reloads at once
      wr_addr_rst = 1'b1;
      tick();
      wr_addr_rst = 1'b0;
      chk("arb_addr_rst", {9'b0, sdram_wr_addr}, 32'd0);

      // write beats read when both are eligible
      wr_fifo_usedw = 10'd8;
      rd_fifo_usedw = 10'd0;
      read_valid    = 1'b1;
      wr_burst(23'd0, 0, 1);
      wr_fifo_usedw = 10'd0;
      rd_burst(23'd100, 0);
      rd_burst(23'd108, 0);
      rd_burst(23'd116, 1);
      rd_burst(23'd100, 0);
      read_valid = 1'b0;
      repeat (3) tick();
      chk("rd_ptr_adv", {9'b0, sdram_rd_addr}, 32'd108);

      // zero burst length never requests
      wr_burst_len  = 10'd0;
      wr_fifo_usedw = 10'd100;
      seen = 0;
      repeat (10) begin
         tick();
         seen |= sdram_wr_req;
      end
      chk("zero_len", {31'b0, seen}, 32'd0);
      wr_burst_len = 10'd8;

      // init_end drop mid-burst: finish, then park in IDLE
      wr_burst(23'd8, 1, 0);
      seen = 0;
      repeat (8) begin
         tick();
         seen |= sdram_wr_req;
      end
      chk("idle_after_drop", {31'b0, seen}, 32'd0);
      chk("ptr_after_drop", {9'b0, sdram_wr_addr}, 32'd16);
      init_end = 1'b1;
      wr_burst(23'd16, 0, 0);
      wr_burst(23'd0, 0, 0);

      // async reset while the request is up
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         if (sdram_wr_req) seen = 1;
         else tick();
      end
      chk("pre_rst_req", {31'b0, seen}, 32'd1);
      chk("pre_rst_addr", {9'b0, sdram_wr_addr}, 32'd8);
      sdram_wr_ack = 1'b1;
      #2;
      sys_rst_n = 1'b0;
      #1;
      chk("rst_req_drop", {31'b0, sdram_wr_req}, 32'd0);
      wr_b_addr    = 23'd40;
      wr_e_addr    = 23'd64;
      sdram_wr_ack = 1'b0;
      repeat (2) tick();
      chk("rst_ptr", {9'b0, sdram_wr_addr}, 32'd40);
      sys_rst_n = 1'b1;
      wr_burst(23'd40, 0, 0);
      wr_fifo_usedw = 10'd0;
      repeat (3) tick();
      chk("post_rst_adv", {9'b0, sdram_wr_addr}, 32'd48);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
